// File: rtl/sfq_dff_stage.sv
// rtl/sfq_dff_stage.sv - clocked RSFQ DFF stage on toggle-encoded pulse lines
// Inputs are synchronised, edge-detected, and blanked for a few cycles after reset.
module sfq_dff_stage #(
   parameter int STARTUP_CYCLES = 4,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_data,
   input  logic             in_clk,
   output logic             out,
   output logic             stored,
   output logic             err,
   output logic [CNT_W-1:0] out_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int             BW        = $clog2(STARTUP_CYCLES + 1);
   localparam logic [BW-1:0]  BLANK_END = BW'(STARTUP_CYCLES);

   logic             r_d_s1, r_d_s2, r_d_s3;
   logic             r_c_s1, r_c_s2, r_c_s3;
   logic [BW-1:0]    r_blank_cnt;
   logic             r_out, r_stored, r_err;
   logic [CNT_W-1:0] r_out_cnt, r_err_cnt;

   logic             w_dp, w_cp, w_blank;
   logic             w_out_nxt, w_stored_nxt, w_err_nxt;
   logic [CNT_W-1:0] w_out_cnt_nxt, w_err_cnt_nxt;

   assign w_dp    = r_d_s2 ^ r_d_s3;
   assign w_cp    = r_c_s2 ^ r_c_s3;
   assign w_blank = (r_blank_cnt < BLANK_END);

   // Readout sees the old stored bit first, so cp & dp together is never an error.
   always_comb begin
      w_out_nxt     = r_out;
      w_stored_nxt  = r_stored;
      w_err_nxt     = 1'b0;
      w_out_cnt_nxt = r_out_cnt;
      w_err_cnt_nxt = r_err_cnt;
      if (!w_blank) begin
         if (w_cp) begin
            if (r_stored) begin
               w_out_nxt     = ~r_out;
               w_out_cnt_nxt = r_out_cnt + CNT_W'(1);
            end
            w_stored_nxt = w_dp;
         end else if (w_dp) begin
            if (r_stored) begin
               w_err_nxt     = 1'b1;
               w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
            end else begin
               w_stored_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_d_s1      <= 1'b0;
         r_d_s2      <= 1'b0;
         r_d_s3      <= 1'b0;
         r_c_s1      <= 1'b0;
         r_c_s2      <= 1'b0;
         r_c_s3      <= 1'b0;
         r_blank_cnt <= '0;
         r_out       <= 1'b0;
         r_stored    <= 1'b0;
         r_err       <= 1'b0;
         r_out_cnt   <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_d_s1 <= in_data;
         r_d_s2 <= r_d_s1;
         r_d_s3 <= r_d_s2;
         r_c_s1 <= in_clk;
         r_c_s2 <= r_c_s1;
         r_c_s3 <= r_c_s2;
         if (w_blank) r_blank_cnt <= r_blank_cnt + BW'(1);
         r_out     <= w_out_nxt;
         r_stored  <= w_stored_nxt;
         r_err     <= w_err_nxt;
         r_out_cnt <= w_out_cnt_nxt;
         r_err_cnt <= w_err_cnt_nxt;
      end
   end

   assign out     = r_out;
   assign stored  = r_stored;
   assign err     = r_err;
   assign out_cnt = r_out_cnt;
   assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_sfq_dff_stage.sv
// tb/tb_sfq_dff_stage.sv - randomized bench with a pulse-level reference model
module tb_sfq_dff_stage;

   localparam int STARTUP = 4;
   localparam int CNT_W   = 2;
   localparam int NCYC    = 3000;

   logic             clk = 1'b0;
   logic             rst_n, in_data, in_clk;
   logic             out, stored, err;
   logic [CNT_W-1:0] out_cnt, err_cnt;

   int checks = 0;
   int failures = 0;

   sfq_dff_stage #(.STARTUP_CYCLES(STARTUP), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_data (in_data),
      .in_clk  (in_clk),
      .out     (out),
      .stored  (stored),
      .err     (err),
      .out_cnt (out_cnt),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: a level change seen at an edge is a pulse that acts two edges later.
   bit m_last_d, m_last_c;
   bit m_pend_d[2];
   bit m_pend_c[2];
   int m_since;
   bit m_out, m_stored, m_err;
   int m_out_cnt, m_err_cnt;

   task automatic model_edge(input bit r, input bit d, input bit c);
      bit dp, cp;
      if (!r) begin
         m_last_d = 0; m_last_c = 0;
         m_pend_d = '{0, 0}; m_pend_c = '{0, 0};
         m_since = 0;
         m_out = 0; m_stored = 0; m_err = 0;
         m_out_cnt = 0; m_err_cnt = 0;
         return;
      end
      dp = m_pend_d[0]; cp = m_pend_c[0];
      m_pend_d[0] = m_pend_d[1]; m_pend_c[0] = m_pend_c[1];
      m_pend_d[1] = (d != m_last_d); m_pend_c[1] = (c != m_last_c);
      m_last_d = d; m_last_c = c;
      m_err = 0;
      if (m_since >= STARTUP) begin
         if (cp) begin
            if (m_stored) begin
               m_out = !m_out;
               m_out_cnt = (m_out_cnt + 1) % (1 << CNT_W);
            end
            m_stored = dp;
         end else if (dp) begin
            if (m_stored) begin
               m_err = 1;
               m_err_cnt = (m_err_cnt + 1) % (1 << CNT_W);
            end else begin
               m_stored = 1;
            end
         end
      end
      if (m_since < STARTUP) m_since++;
   endtask

   initial begin
      int rst_left, gap_d, gap_c;
      rst_n = 1'b0; in_data = 1'b1; in_clk = 1'b0;
      rst_left = 3; gap_d = 0; gap_c = 0;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         model_edge(rst_n, in_data, in_clk);
         chk("out",     {31'd0, out},     {31'd0, m_out});
         chk("stored",  {31'd0, stored},  {31'd0, m_stored});
         chk("err",     {31'd0, err},     {31'd0, m_err});
         chk("out_cnt", 32'(out_cnt),     32'(m_out_cnt));
         chk("err_cnt", 32'(err_cnt),     32'(m_err_cnt));
         if (rst_left > 0) begin
            rst_left--;
            rst_n = 1'b0;
         end else if ($urandom_range(0, 149) == 0) begin
            rst_left = $urandom_range(0, 2);
            rst_n = 1'b0;
         end else begin
            rst_n = 1'b1;
         end
         gap_d++; gap_c++;
         if (gap_d >= 2 && $urandom_range(0, 2) == 0) begin
            in_data = ~in_data; gap_d = 0;
         end
         if (gap_c >= 2 && $urandom_range(0, 2) == 0) begin
            in_clk = ~in_clk; gap_c = 0;
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
